// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: the blank segment
// word and the active-low hex glyph table, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Entry 15 first so HEX_SEG_TABLE[n] selects the glyph for nibble n.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] I_hex,
    output logic [6:0] O_seg
);

    // Table lookup of the glyph for the incoming nibble
    always_comb begin
        O_seg = HEX_SEG_TABLE[I_hex];
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: time-slices N_DIGITS digits,
// applies a blank guard and PWM-style brightness window per slot, and shows
// frame-consistent data captured once per frame.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic                  I_clk,
    input  logic                  I_rst_n,
    input  logic                  I_en,
    input  logic [4*N_DIGITS-1:0] I_data,
    input  logic [N_DIGITS-1:0]   I_dp,
    input  logic                  I_lz_en,
    input  logic [3:0]            I_bright,
    output logic [N_DIGITS-1:0]   O_an,
    output logic [7:0]            O_seg,
    output logic                  O_frame
);

    localparam int unsigned STEP = (SCAN_DIV - BLANK_CYC) / 15;
    localparam int unsigned CW   = $clog2(SCAN_DIV);
    localparam int unsigned IW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

    if (SCAN_DIV < BLANK_CYC + 15) begin : g_bad_scan_div
        $error("seg_scan_ctrl: SCAN_DIV must be >= BLANK_CYC + 15");
    end
    if (N_DIGITS < 2 || N_DIGITS > 8) begin : g_bad_n_digits
        $error("seg_scan_ctrl: N_DIGITS must be in 2..8");
    end

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*N_DIGITS-1:0] sh_data_q, sh_data_d;
    logic [N_DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic                  sh_lz_q, sh_lz_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic [7:0]            seg_q, seg_d;
    logic                  frame_q, frame_d;

    logic                  on_win;
    logic [31:0]           cnt_ext;
    logic [31:0]           win_end;
    logic [N_DIGITS-1:0]   lz_blank;
    logic                  upper_zero;
    logic [N_DIGITS-1:0]   sel_onehot;
    logic [3:0]            nib;
    logic                  dp_bit;
    logic                  blank_sel;
    logic [6:0]            seg_pat;

    hex_to_seg u_dec (
        .I_hex (nib),
        .O_seg (seg_pat)
    );

    // Slot/digit counters; shadow capture and frame pulse on the digit wrap
    always_comb begin
        cnt_d     = cnt_q + CW'(1);
        idx_d     = idx_q;
        sh_data_d = sh_data_q;
        sh_dp_d   = sh_dp_q;
        sh_lz_d   = sh_lz_q;
        frame_d   = 1'b0;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d     = '0;
                sh_data_d = I_data;
                sh_dp_d   = I_dp;
                sh_lz_d   = I_lz_en;
                frame_d   = 1'b1;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    // Brightness on-window within the slot, after the anti-ghost blank
    always_comb begin
        cnt_ext = 32'(cnt_q);
        win_end = 32'(BLANK_CYC) + 32'(I_bright) * 32'(STEP);
        on_win  = (cnt_ext >= 32'(BLANK_CYC)) && (cnt_ext < win_end);
    end

    // Leading-zero mask: walk from the top digit down while nibbles stay zero
    always_comb begin
        upper_zero = 1'b1;
        lz_blank   = '0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            upper_zero = upper_zero && (sh_data_q[4*(N_DIGITS-1-i) +: 4] == 4'h0);
            lz_blank[N_DIGITS-1-i] = upper_zero && sh_lz_q && (N_DIGITS - 1 - i != 0);
        end
    end

    // Select the active digit's nibble, dp bit and suppression flag
    always_comb begin
        nib        = '0;
        dp_bit     = 1'b0;
        blank_sel  = 1'b0;
        sel_onehot = '0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                nib           = sh_data_q[4*i +: 4];
                dp_bit        = sh_dp_q[i];
                blank_sel     = lz_blank[i];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    // Next anode/segment words; segments follow the window, anodes also gate on enable
    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        if (on_win) begin
            seg_d = {~dp_bit, seg_pat};
            if (I_en && !blank_sel) begin
                an_d = ~sel_onehot;
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            sh_data_q <= '0;
            sh_dp_q   <= '0;
            sh_lz_q   <= 1'b0;
            an_q      <= '1;
            seg_q     <= SEG_OFF;
            frame_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sh_data_q <= sh_data_d;
            sh_dp_q   <= sh_dp_d;
            sh_lz_q   <= sh_lz_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            frame_q   <= frame_d;
        end
    end

    assign O_an    = an_q;
    assign O_seg   = seg_q;
    assign O_frame = frame_q;

endmodule
